// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if
// Bundles the pipeline-side handshake and status signals of the stall
// controller.
//
// Handshake: none of these signals uses valid/ready flow control. All inputs
// are level signals sampled every clk edge. sram_ready is a per-cycle
// completion strobe: an access is done in any cycle where a MEM-stage request
// (mem_r_en | mem_w_en) or an outstanding wait coincides with sram_ready=1.
//
// Signals (controller = slave, pipeline/bench = master):
//   hazard, branch_taken        : hazard unit / EXE branch resolution
//   mem_r_en, mem_w_en          : MEM-stage load / store request
//   sram_ready                  : SRAM access completes this cycle
//   freeze_front, freeze_back   : hold PC+IF/ID, hold ID/EX..MEM/WB
//   flush_if_id, flush_id_ex    : insert bubbles
//   mem_stall, mem_error        : waiting on SRAM, sticky timeout flag
//   hazard_cnt, mem_wait_cnt    : saturating stall statistics
//   dbg_state                   : FSM state (0=RUN, 1=WAIT, 2=ERROR)
interface pipeline_stall_controller_if #(
   parameter int CNT_W = 16
);
   logic             hazard;
   logic             branch_taken;
   logic             mem_r_en;
   logic             mem_w_en;
   logic             sram_ready;
   logic             freeze_front;
   logic             freeze_back;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             mem_stall;
   logic             mem_error;
   logic [CNT_W-1:0] hazard_cnt;
   logic [CNT_W-1:0] mem_wait_cnt;
   logic [1:0]       dbg_state;

   modport master (
      output hazard, branch_taken, mem_r_en, mem_w_en, sram_ready,
      input  freeze_front, freeze_back, flush_if_id, flush_id_ex,
             mem_stall, mem_error, hazard_cnt, mem_wait_cnt, dbg_state
   );

   modport slave (
      input  hazard, branch_taken, mem_r_en, mem_w_en, sram_ready,
      output freeze_front, freeze_back, flush_if_id, flush_id_ex,
             mem_stall, mem_error, hazard_cnt, mem_wait_cnt, dbg_state
   );
endinterface

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central freeze/flush sequencer for the 5-stage pipeline. Combines the data
// hazard flag, the EXE branch-taken flag and the SRAM handshake of MEM-stage
// accesses into freeze/flush controls, guards memory waits with a timeout
// (ERROR state, sticky mem_error) and keeps saturating stall statistics.
//
// Ports:
//   clk   : pipeline clock, rising edge
//   rst   : synchronous reset, active-low
//   bus   : pipeline_stall_controller_if.slave (see interface header)
//
// Parameters:
//   MEM_TIMEOUT : consecutive memory-stall cycles that trigger ERROR (2..255)
//   CNT_W       : width of the statistics counters (must match bus CNT_W)
module pipeline_stall_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   pipeline_stall_controller_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [7:0]       r_wait_cnt;
   logic             r_mem_error;
   logic [CNT_W-1:0] r_hazard_cnt;
   logic [CNT_W-1:0] r_mem_wait_cnt;

   logic             w_mem_req;
   logic             w_mem_stall;
   logic             w_timeout;
   logic             w_hazard_stall;

   assign w_mem_req = bus.mem_r_en | bus.mem_w_en;

   // In WAIT the access is already outstanding, so only sram_ready matters.
   always_comb begin
      w_mem_stall = 1'b0;
      case (r_state)
         ST_RUN:  w_mem_stall = w_mem_req & ~bus.sram_ready;
         ST_WAIT: w_mem_stall = ~bus.sram_ready;
         default: w_mem_stall = 1'b0;
      endcase
   end

   // r_wait_cnt counts stall cycles already completed, so this fires on the
   // MEM_TIMEOUT-th consecutive stall cycle.
   assign w_timeout = w_mem_stall && (r_wait_cnt == 8'(MEM_TIMEOUT - 1));

   // A hazard only costs a cycle when not masked by a branch or a memory stall.
   assign w_hazard_stall = bus.hazard & ~bus.branch_taken & ~w_mem_stall &
                           (r_state != ST_ERROR);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_RUN;
      else      r_state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_timeout)        w_next_state = ST_ERROR;
            else if (w_mem_stall) w_next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_timeout)           w_next_state = ST_ERROR;
            else if (bus.sram_ready) w_next_state = ST_RUN;
         end
         ST_ERROR: w_next_state = ST_ERROR;
         default:  w_next_state = ST_RUN;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Memory stall overrides hazard/branch; branch beats hazard because the
   // hazarding instruction is on the wrong path.
   always_comb begin
      bus.freeze_front = 1'b0;
      bus.freeze_back  = 1'b0;
      bus.flush_if_id  = 1'b0;
      bus.flush_id_ex  = 1'b0;
      bus.mem_stall    = 1'b0;
      if (rst) begin
         bus.mem_stall = w_mem_stall;
         if (r_state == ST_ERROR || w_mem_stall) begin
            bus.freeze_front = 1'b1;
            bus.freeze_back  = 1'b1;
         end else begin
            bus.freeze_front = bus.hazard & ~bus.branch_taken;
            bus.flush_if_id  = bus.branch_taken;
            bus.flush_id_ex  = bus.branch_taken | bus.hazard;
         end
      end
   end

   // ---------------- timeout counter and error flag ----------------
   // In ERROR the counter simply holds; only reset leaves that state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wait_cnt  <= 8'd0;
         r_mem_error <= 1'b0;
      end else begin
         if (w_mem_stall)            r_wait_cnt <= r_wait_cnt + 8'd1;
         else if (r_state != ST_ERROR) r_wait_cnt <= 8'd0;
         if (w_timeout) r_mem_error <= 1'b1;
      end
   end

   // ---------------- saturating statistics ----------------
   // mem_stall is never 1 in ERROR, so neither counter advances there.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hazard_cnt   <= '0;
         r_mem_wait_cnt <= '0;
      end else begin
         if (w_hazard_stall && (r_hazard_cnt != {CNT_W{1'b1}}))
            r_hazard_cnt <= r_hazard_cnt + 1'b1;
         if (w_mem_stall && (r_mem_wait_cnt != {CNT_W{1'b1}}))
            r_mem_wait_cnt <= r_mem_wait_cnt + 1'b1;
      end
   end

   assign bus.mem_error    = r_mem_error;
   assign bus.hazard_cnt   = r_hazard_cnt;
   assign bus.mem_wait_cnt = r_mem_wait_cnt;
   assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller
// Directed bench for pipeline_stall_controller. Two instances share the same
// stimulus: the main one (MEM_TIMEOUT=16, CNT_W=16) and a narrow-counter one
// (CNT_W=4) used for the saturation case.
module tb_pipeline_stall_controller;

   localparam logic [1:0] RUN = 2'd0, WAIT = 2'd1, ERR = 2'd2;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   pipeline_stall_controller_if #(.CNT_W(16)) bus ();
   pipeline_stall_controller_if #(.CNT_W(4))  bus_s ();

   pipeline_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipeline_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic h, input logic bt, input logic r,
                         input logic w, input logic rdy);
      bus.hazard       = h;   bus_s.hazard       = h;
      bus.branch_taken = bt;  bus_s.branch_taken = bt;
      bus.mem_r_en     = r;   bus_s.mem_r_en     = r;
      bus.mem_w_en     = w;   bus_s.mem_w_en     = w;
      bus.sram_ready   = rdy; bus_s.sram_ready   = rdy;
      #1;
   endtask

   // Advance one edge and settle, leaving time for new inputs before the next.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic ff, input logic fb,
                          input logic fi, input logic fe, input logic ms);
      chk({tag, ".freeze_front"}, 32'(bus.freeze_front), 32'(ff));
      chk({tag, ".freeze_back"},  32'(bus.freeze_back),  32'(fb));
      chk({tag, ".flush_if_id"},  32'(bus.flush_if_id),  32'(fi));
      chk({tag, ".flush_id_ex"},  32'(bus.flush_id_ex),  32'(fe));
      chk({tag, ".mem_stall"},    32'(bus.mem_stall),    32'(ms));
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] st,
                          input logic err, input int hc, input int mc);
      chk({tag, ".state"},        32'(bus.dbg_state),    32'(st));
      chk({tag, ".mem_error"},    32'(bus.mem_error),    32'(err));
      chk({tag, ".hazard_cnt"},   32'(bus.hazard_cnt),   32'(hc));
      chk({tag, ".mem_wait_cnt"}, 32'(bus.mem_wait_cnt), 32'(mc));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b0;
      set_in(0, 0, 0, 0, 0);
      step();
      step();

      // Reset held: outputs forced low even with active inputs.
      set_in(1, 1, 1, 0, 0);
      chk_ctl("rst_low", 0, 0, 0, 0, 0);
      chk_reg("rst_low", RUN, 0, 0, 0);
      set_in(0, 0, 0, 0, 0);
      rst = 1'b1;
      step();

      // Idle.
      chk_ctl("idle", 0, 0, 0, 0, 0);
      chk_reg("idle", RUN, 0, 0, 0);

      // Hazard for 3 cycles.
      set_in(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk_ctl("hazard", 1, 0, 0, 1, 0);
         step();
      end
      chk_reg("hazard_done", RUN, 0, 3, 0);

      // Hazard + branch: branch wins, not counted.
      set_in(1, 1, 0, 0, 0);
      chk_ctl("haz_branch", 0, 0, 1, 1, 0);
      step();
      chk_reg("haz_branch", RUN, 0, 3, 0);

      // Load waiting 4 cycles, hazard asserted during stall not counted.
      set_in(1, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk_ctl("load_wait", 1, 1, 0, 0, 1);
         step();
         chk("load_wait.state", 32'(bus.dbg_state), 32'(WAIT));
      end
      set_in(0, 0, 1, 0, 1);
      chk_ctl("load_ready", 0, 0, 0, 0, 0);
      step();
      chk_reg("load_done", RUN, 0, 3, 4);

      // Zero-wait store: no stall, no count.
      set_in(0, 0, 0, 1, 1);
      chk_ctl("zero_wait", 0, 0, 0, 0, 0);
      step();
      chk_reg("zero_wait", RUN, 0, 3, 4);

      // Back-to-back accesses: wait, ready, wait again from RUN.
      set_in(0, 0, 1, 0, 0);
      step();
      chk("b2b_1.state", 32'(bus.dbg_state), 32'(WAIT));
      set_in(0, 0, 1, 0, 1);
      step();
      chk("b2b_ready.state", 32'(bus.dbg_state), 32'(RUN));
      set_in(0, 0, 1, 0, 0);
      chk_ctl("b2b_2", 1, 1, 0, 0, 1);
      step();
      chk_reg("b2b_2", WAIT, 0, 3, 6);
      set_in(0, 0, 1, 0, 1);
      step();
      chk("b2b_done.state", 32'(bus.dbg_state), 32'(RUN));

      // 15 stall cycles then ready: just short of the timeout.
      set_in(0, 0, 1, 0, 0);
      for (int i = 0; i < 15; i++) step();
      chk_reg("near_to", WAIT, 0, 3, 21);
      set_in(0, 0, 1, 0, 1);
      chk_ctl("near_to_ready", 0, 0, 0, 0, 0);
      step();
      chk_reg("near_to_done", RUN, 0, 3, 21);

      // Store never ready: ERROR after exactly 16 stall cycles.
      set_in(0, 0, 0, 1, 0);
      for (int i = 0; i < 15; i++) step();
      chk_reg("timeout_15", WAIT, 0, 3, 36);
      step();
      chk_reg("timeout_16", ERR, 1, 3, 37);
      chk_ctl("error", 1, 1, 0, 0, 0);

      // ERROR holds and counts nothing, even with ready and hazard.
      set_in(1, 0, 1, 0, 1);
      chk_ctl("error_hold", 1, 1, 0, 0, 0);
      step();
      step();
      chk_reg("error_hold", ERR, 1, 3, 37);

      // Reset out of ERROR: outputs low in the same cycle.
      rst = 1'b0;
      #1;
      chk_ctl("err_rst_low", 0, 0, 0, 0, 0);
      step();
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0);
      chk_reg("err_reset", RUN, 0, 0, 0);
      chk("err_reset.sat_hc", 32'(bus_s.hazard_cnt), 32'd0);

      // Saturation of the 4-bit counter.
      set_in(1, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) step();
      chk("sat_15.hazard_cnt", 32'(bus_s.hazard_cnt), 32'd15);
      for (int i = 0; i < 5; i++) step();
      chk("sat_20.hazard_cnt", 32'(bus_s.hazard_cnt), 32'd15);
      chk("wide_20.hazard_cnt", 32'(bus.hazard_cnt), 32'd20);
      set_in(0, 0, 0, 0, 0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   // Watchdog: the directed sequence is short; never hang.
   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
